// File: rtl/arm_fetch_pkg.sv
// Shared fetch-unit definitions: datapath widths, fetch FSM states and the default boot address.
package arm_fetch_pkg;

   localparam int unsigned ADDR_W  = 64;
   localparam int unsigned INSTR_W = 32;

   localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = '0;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      DROP
   } fetch_state_e;

   // Instruction fetches are always word aligned; the low two address bits are ignored.
   function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] a);
      return a & ~ADDR_W'(3);
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Power-of-two instruction FIFO with flush; a push while full or a pop while empty is ignored.
module fetch_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 96
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_push,
   input  logic                   i_pop,
   input  logic                   i_flush,
   input  logic [WIDTH-1:0]       i_wdata,
   output logic [WIDTH-1:0]       o_rdata,
   output logic [$clog2(DEPTH):0] o_count,
   output logic                   o_full,
   output logic                   o_empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push;
   logic             w_pop;

   assign w_push = i_push && !o_full;
   assign w_pop  = i_pop && !o_empty;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset: the head is only looked at while the FIFO is non-empty.
   always_ff @(posedge i_clk) begin
      if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
   end

   assign o_rdata = r_mem[r_rd_ptr];
   assign o_count = r_count;
   assign o_full  = (r_count == CNT_W'(DEPTH));
   assign o_empty = (r_count == '0);

endmodule

// File: rtl/instr_fetch_buffer.sv
// Instruction fetch front end: issues word reads, buffers returned instructions for decode and
// handles redirects, discarding any response that belongs to the pre-redirect stream.
module instr_fetch_buffer
   import arm_fetch_pkg::*;
#(
   parameter int unsigned       FIFO_DEPTH = 4,
   parameter logic [ADDR_W-1:0] RESET_PC   = DEFAULT_RESET_PC
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_redirect,
   input  logic [ADDR_W-1:0]  i_redirect_pc,
   output logic               o_mem_req,
   output logic [ADDR_W-1:0]  o_mem_addr,
   input  logic               i_mem_ack,
   input  logic [INSTR_W-1:0] i_mem_rdata,
   output logic               o_instr_valid,
   output logic [INSTR_W-1:0] o_instr,
   output logic [ADDR_W-1:0]  o_instr_pc,
   input  logic               i_instr_ready
);

   localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned DATA_W = INSTR_W + ADDR_W;

   fetch_state_e      r_state;
   logic [ADDR_W-1:0] r_fa;
   logic              r_mem_req;
   logic [ADDR_W-1:0] r_mem_addr;

   logic [ADDR_W-1:0]  w_redirect_pc;
   logic [ADDR_W-1:0]  w_fa_inc;
   logic               w_push;
   logic               w_pop;
   logic [CNT_W-1:0]   w_count;
   logic               w_full;
   logic               w_empty;
   logic               w_full_after_push;
   logic [DATA_W-1:0]  w_rdata;
   logic [INSTR_W-1:0] w_head_instr;
   logic [ADDR_W-1:0]  w_head_pc;

   assign w_redirect_pc = align_word(i_redirect_pc);
   assign w_fa_inc      = r_fa + ADDR_W'(4);

   // A response arriving together with a redirect belongs to the old stream and is dropped.
   assign w_push = (r_state == REQ) && i_mem_ack && !i_redirect;
   assign w_pop  = !w_empty && i_instr_ready;

   assign w_full_after_push = (w_count == CNT_W'(FIFO_DEPTH - 1)) && !w_pop;

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_W)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (i_redirect),
      .i_wdata ({i_mem_rdata, r_mem_addr}),
      .o_rdata (w_rdata),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // In REQ the fetch address always equals the outstanding request address.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= IDLE;
         r_fa       <= RESET_PC;
         r_mem_req  <= 1'b0;
         r_mem_addr <= '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (i_redirect) begin
                  r_fa <= w_redirect_pc;
               end else if (!w_full) begin
                  r_state    <= REQ;
                  r_mem_req  <= 1'b1;
                  r_mem_addr <= r_fa;
               end
            end
            REQ: begin
               if (i_redirect) begin
                  r_fa <= w_redirect_pc;
                  if (i_mem_ack) r_mem_addr <= w_redirect_pc;
                  else           r_state    <= DROP;
               end else if (i_mem_ack) begin
                  r_fa <= w_fa_inc;
                  if (w_full_after_push) begin
                     r_state   <= IDLE;
                     r_mem_req <= 1'b0;
                  end else begin
                     r_mem_addr <= w_fa_inc;
                  end
               end
            end
            DROP: begin
               if (i_redirect) r_fa <= w_redirect_pc;
               if (i_mem_ack) begin
                  r_state    <= REQ;
                  r_mem_addr <= i_redirect ? w_redirect_pc : r_fa;
               end
            end
            default: begin
               r_state   <= IDLE;
               r_mem_req <= 1'b0;
            end
         endcase
      end
   end

   assign {w_head_instr, w_head_pc} = w_rdata;

   assign o_mem_req     = r_mem_req;
   assign o_mem_addr    = r_mem_addr;
   assign o_instr_valid = !w_empty;
   assign o_instr       = w_empty ? '0 : w_head_instr;
   assign o_instr_pc    = w_empty ? '0 : w_head_pc;

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Bench for instr_fetch_buffer: directed corner cases plus randomized traffic, with a stream
// model scoreboard checking every instruction handed to decode.
module tb_instr_fetch_buffer;

   localparam int unsigned DEPTH  = 4;
   localparam logic [63:0] RST_PC = 64'h0;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        redirect;
   logic [63:0] redirect_pc;
   logic        mem_req;
   logic [63:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        instr_valid;
   logic [31:0] instr;
   logic [63:0] instr_pc;
   logic        instr_ready;

   always #5 clk = ~clk;

   instr_fetch_buffer #(
      .FIFO_DEPTH (DEPTH),
      .RESET_PC   (RST_PC)
   ) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_redirect    (redirect),
      .i_redirect_pc (redirect_pc),
      .o_mem_req     (mem_req),
      .o_mem_addr    (mem_addr),
      .i_mem_ack     (mem_ack),
      .i_mem_rdata   (mem_rdata),
      .o_instr_valid (instr_valid),
      .o_instr       (instr),
      .o_instr_pc    (instr_pc),
      .i_instr_ready (instr_ready)
   );

   int checks = 0;
   int errors = 0;
   int n_deliv = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Instruction memory contents as a pure function of the address.
   function automatic logic [31:0] mem_word(input logic [63:0] a);
      return (a[33:2] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5EED_0000;
   endfunction

   // Memory responder state
   bit          new_req = 1'b1;
   int          cnt = 0;
   int          cur_lat = 0;
   int          fixed_lat = 0;
   bit          pend = 1'b0;
   logic [63:0] pend_addr = '0;
   bit          last_redirect = 1'b0;
   logic [63:0] ack_log[$];

   // Advance to just after the next rising edge and check the memory-side protocol.
   task automatic tick();
      @(posedge clk);
      #1;
      if (rst_n) begin
         if (pend) begin
            chk("req_held", mem_req, 1'b1);
            chk("addr_held", mem_addr, pend_addr);
         end
         if (last_redirect) chk("flush_valid", instr_valid, 1'b0);
         if (mem_req) chk("addr_align", mem_addr[1:0], 2'b00);
      end
   endtask

   // Drive decode/redirect inputs and the memory response for the current cycle.
   task automatic drive(input bit redir, input logic [63:0] tgt, input bit rdy);
      redirect      = redir;
      redirect_pc   = tgt;
      instr_ready   = rdy;
      last_redirect = redir && rst_n;
      pend          = 1'b0;
      mem_ack       = 1'b0;
      mem_rdata     = $urandom;
      if (rst_n && mem_req) begin
         if (new_req) begin
            cnt     = 0;
            cur_lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(3, 0));
            new_req = 1'b0;
         end
         if (cnt == cur_lat) begin
            mem_ack   = 1'b1;
            mem_rdata = mem_word(mem_addr);
            new_req   = 1'b1;
            ack_log.push_back(mem_addr);
         end else begin
            pend      = 1'b1;
            pend_addr = mem_addr;
         end
         cnt++;
      end
   endtask

   task automatic do_reset();
      rst_n         = 1'b0;
      redirect      = 1'b0;
      redirect_pc   = '0;
      instr_ready   = 1'b0;
      mem_ack       = 1'b0;
      mem_rdata     = '0;
      new_req       = 1'b1;
      pend          = 1'b0;
      last_redirect = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req", mem_req, 1'b0);
      chk("rst_addr", mem_addr, 64'h0);
      chk("rst_valid", instr_valid, 1'b0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_pc", instr_pc, 64'h0);
      rst_n = 1'b1;
   endtask

   // Scoreboard: the expected delivery stream restarts at reset and at every redirect target.
   logic [63:0] exp_q[$];
   logic [63:0] m_next = RST_PC;

   initial begin
      logic [63:0] e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            exp_q.delete();
            m_next = RST_PC;
         end else begin
            if (instr_valid && instr_ready) begin
               if (exp_q.size() == 0) begin
                  for (int i = 0; i < 8; i++) begin
                     exp_q.push_back(m_next);
                     m_next = m_next + 64'd4;
                  end
               end
               e = exp_q.pop_front();
               chk("deliver", {instr_pc, instr}, {e, mem_word(e)});
               n_deliv++;
            end
            // A handshake in the redirect cycle still belongs to the old stream.
            if (redirect) begin
               exp_q.delete();
               m_next = redirect_pc & ~64'h3;
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      bit          got;
      int          start_deliv;
      logic [63:0] tgt;
      bit          r;
      rst_n = 1'b0;

      // Zero-wait memory, decode always ready
      fixed_lat = 0;
      do_reset();
      drive(0, '0, 1);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("seq_req", mem_req, 1'b1);
         chk("seq_addr", mem_addr, 64'(4 * k));
         if (k > 0) begin
            chk("seq_valid", instr_valid, 1'b1);
            chk("seq_pc", instr_pc, 64'(4 * (k - 1)));
         end
         drive(0, '0, 1);
      end
      repeat (4) begin tick(); drive(0, '0, 1); end

      // Decode stalled: FIFO fills with four entries, then fetch resumes at 0x10
      do_reset();
      ack_log.delete();
      drive(0, '0, 0);
      repeat (6) begin tick(); drive(0, '0, 0); end
      chk("full_pushes", ack_log.size(), 4);
      for (int i = 0; i < 4 && i < ack_log.size(); i++) chk("full_addr", ack_log[i], 64'(4 * i));
      chk("full_idle", mem_req, 1'b0);
      chk("full_head", instr_pc, 64'h0);
      drive(0, '0, 1);
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         tick();
         if (mem_req) got = 1'b1;
         drive(0, '0, 1);
      end
      chk("resume_seen", got, 1'b1);
      chk("resume_addr", mem_addr, 64'h10);
      repeat (8) begin tick(); drive(0, '0, 1); end

      // Redirect while a 3-cycle request to 0x8 is outstanding
      fixed_lat = 3;
      do_reset();
      drive(0, '0, 1);
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         tick();
         if (mem_req && mem_addr == 64'h8) begin
            got = 1'b1;
            drive(1, 64'h1002, 1);
         end else begin
            drive(0, '0, 1);
         end
      end
      chk("drop_found", got, 1'b1);
      tick();
      chk("drop_req", mem_req, 1'b1);
      chk("drop_addr", mem_addr, 64'h8);
      drive(0, '0, 1);
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         tick();
         if (mem_addr != 64'h8) got = 1'b1;
         drive(0, '0, 1);
      end
      chk("drop_next_addr", mem_addr, 64'h1000);
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         tick();
         if (instr_valid) got = 1'b1;
         else drive(0, '0, 1);
      end
      chk("drop_first_pc", {got, instr_pc}, {1'b1, 64'h1000});
      drive(0, '0, 1);
      repeat (4) begin tick(); drive(0, '0, 1); end

      // Redirect in the same cycle as the ack for 0x10
      fixed_lat = 0;
      do_reset();
      drive(0, '0, 1);
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         tick();
         if (mem_req && mem_addr == 64'h10) begin
            got = 1'b1;
            drive(1, 64'h40, 1);
         end else begin
            drive(0, '0, 1);
         end
      end
      chk("ackredir_found", got, 1'b1);
      tick();
      chk("ackredir_req", mem_req, 1'b1);
      chk("ackredir_addr", mem_addr, 64'h40);
      chk("ackredir_empty", instr_valid, 1'b0);
      drive(0, '0, 1);
      tick();
      chk("ackredir_pc", {instr_valid, instr_pc}, {1'b1, 64'h40});
      drive(0, '0, 1);
      repeat (4) begin tick(); drive(0, '0, 1); end

      // Address wrap at the top of the address space
      fixed_lat = -1;
      do_reset();
      ack_log.delete();
      drive(1, 64'hFFFF_FFFF_FFFF_FFF8, 1);
      for (int i = 0; i < 30 && ack_log.size() < 3; i++) begin tick(); drive(0, '0, 1); end
      chk("wrap_count", ack_log.size() >= 3, 1'b1);
      if (ack_log.size() >= 3) begin
         chk("wrap_a0", ack_log[0], 64'hFFFF_FFFF_FFFF_FFF8);
         chk("wrap_a1", ack_log[1], 64'hFFFF_FFFF_FFFF_FFFC);
         chk("wrap_a2", ack_log[2], 64'h0);
      end
      repeat (6) begin tick(); drive(0, '0, 1); end

      // Asynchronous reset while a request is outstanding
      fixed_lat = 3;
      do_reset();
      drive(0, '0, 0);
      repeat (6) begin tick(); drive(0, '0, 0); end
      chk("midreq_pre_req", mem_req, 1'b1);
      chk("midreq_pre_valid", instr_valid, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_req", mem_req, 1'b0);
      chk("async_addr", mem_addr, 64'h0);
      chk("async_valid", instr_valid, 1'b0);
      chk("async_instr", instr, 32'h0);
      chk("async_pc", instr_pc, 64'h0);
      new_req       = 1'b1;
      pend          = 1'b0;
      last_redirect = 1'b0;
      mem_ack       = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive(0, '0, 1);
      tick();
      chk("post_rst_req", mem_req, 1'b1);
      chk("post_rst_addr", mem_addr, RST_PC);
      drive(0, '0, 1);

      // Randomized traffic
      fixed_lat = -1;
      do_reset();
      drive(0, '0, 1);
      start_deliv = n_deliv;
      for (int c = 0; c < 3000; c++) begin
         tick();
         r = ($urandom_range(19, 0) == 0);
         if ($urandom_range(3, 0) == 0) tgt = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(15, 0));
         else                           tgt = {32'h0, $urandom};
         drive(r, tgt, $urandom_range(9, 0) < 7);
      end
      repeat (10) begin tick(); drive(0, '0, 1); end
      chk("random_progress", (n_deliv - start_deliv) > 200, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/instr_fetch_buffer.md
INSTR_FETCH_BUFFER -- requirements
Module: instr_fetch_buffer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, number of buffered instructions; SHALL be a power of two and at least 2.
REQ-002 Parameter RESET_PC, default 64'h0, first fetch address after reset.
REQ-003 Clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 Rst  input  1  reset, asynchronous, active-low.
REQ-005 Redirect  input  1  one-cycle pulse that loads a new fetch address (branch or CBZ taken).
REQ-006 RedirectPC  input  64  new fetch address, sampled when Redirect=1.
REQ-007 MemReq  output  1  instruction-memory read request.
REQ-008 MemAddr  output  64  word-aligned read address.
REQ-009 MemAck  input  1  one-cycle pulse; MemRdata is valid in the same cycle.
REQ-010 MemRdata  input  32  instruction word.
REQ-011 InstrValid  output  1  head FIFO entry is available to decode.
REQ-012 Instr  output  32  head instruction word.
REQ-013 InstrPC  output  64  address of the head instruction.
REQ-014 InstrReady  input  1  decode accepts the head entry when InstrValid=1 and InstrReady=1.

Function
REQ-015 The block SHALL keep a 64-bit fetch address FA; each accepted memory request SHALL advance FA by 4, wrapping from 64'hFFFF_FFFF_FFFF_FFFC to 0.
REQ-016 A redirect SHALL load FA with {RedirectPC[63:2],2'b00}; RedirectPC[1:0] SHALL be ignored.
REQ-017 The state machine SHALL have three states: IDLE (no request outstanding), REQ (MemReq=1, waiting for MemAck) and DROP (request outstanding but its data is stale).
REQ-018 IDLE SHALL move to REQ when (FIFO count + 0) < FIFO_DEPTH and there is no Redirect this cycle.
REQ-019 In REQ, MemReq and MemAddr SHALL stay stable until MemAck=1; a request SHALL never be withdrawn.
REQ-020 REQ with MemAck=1 SHALL push {MemRdata, MemAddr} into the FIFO, advance FA, and stay in REQ with the new MemAddr on the next cycle if space remains after the push; otherwise it SHALL move to IDLE.
REQ-021 REQ with Redirect=1 and MemAck=0 SHALL move to DROP; DROP SHALL hold MemReq=1 with the old address, discard the data on MemAck, and then move to REQ at FA.
REQ-022 Redirect SHALL flush the FIFO (count=0, InstrValid=0 on the next cycle).
REQ-023 When Redirect and MemAck occur in the same cycle, the acknowledged data SHALL be discarded and the next cycle SHALL request the redirect address.
REQ-024 When Redirect and a decode handshake occur in the same cycle, the handshake SHALL complete (that entry is consumed) and the flush SHALL still apply.
REQ-025 When Redirect occurs in DROP, FA SHALL be reloaded and the state SHALL remain DROP.
REQ-026 A push and a pop in the same cycle SHALL leave the count unchanged; a push SHALL never occur when the FIFO is full.
REQ-027 Latency from MemAck to InstrValid SHALL be one cycle; instructions SHALL be delivered in fetch order.

Reset
REQ-028 While Rst=0: MemReq=0, MemAddr=0, InstrValid=0, Instr=0, InstrPC=0, FA=RESET_PC, FIFO empty, state IDLE.
REQ-029 Asserting reset while a request is outstanding SHALL abandon it; the memory model SHALL discard any outstanding request when reset is asserted.
REQ-030 In the first cycle after Rst rises, MemReq SHALL be 1 with MemAddr=RESET_PC.

Structure
REQ-031 A shared package arm_fetch_pkg SHALL hold ADDR_W=64, INSTR_W=32, the fetch-state enum (IDLE, REQ, DROP) and the default RESET_PC.
REQ-032 The FIFO SHALL be a sub-module, fetch_fifo, with push, pop, flush, count, full and empty signals.

Verification
REQ-033 Reset release with zero-wait memory (MemAck in the request cycle) and InstrReady=1 -> MemAddr sequence 0,4,8,C, one per cycle; InstrPC trails MemAddr by one cycle.
REQ-034 InstrReady=0 with FIFO_DEPTH=4 -> exactly four pushes at addresses 0..C, then MemReq=0; raising InstrReady resumes at address 10.
REQ-035 Redirect to 0x1002 while a request to 0x8 is outstanding with a 3-cycle MemAck -> the 0x8 data is discarded, the next MemAddr is 0x1000, and the first InstrPC after the redirect is 0x1000.
REQ-036 Redirect to 0x40 in the same cycle as MemAck for 0x10 -> 0x10 is never delivered, MemAddr=0x40 on the next cycle, and the FIFO is empty on the next cycle.
REQ-037 Redirect to 64'hFFFF_FFFF_FFFF_FFF8 -> fetch addresses ...FFF8, ...FFFC, then 0x0.
REQ-038 Rst pulled low mid-REQ -> all outputs are 0 asynchronously, and after release MemAddr=RESET_PC.
